data_sync_tx: RTL

Source-domain transmitter for a multi-bit bus that crosses to a destination clock domain. The destination synchronizes only the enable bit and captures the bus when the synchronized enable rises.
Accepts words over a valid/ready handshake, drives a held-stable bus plus a level enable, and runs a 4-phase req/ack handshake. The ack is the destination's synchronized copy of bus_enable, returned asynchronously.
Guarantees the bus never changes while the destination may be sampling it. Sits at the register-file/UART-config boundary, paired with the destination-side bus synchronizer.

---
 rtl/data_sync_tx.sv | 112 +++++++++++
 1 files changed

// File: rtl/data_sync_tx.sv
// data_sync_tx
//   Source-side transmitter for a multi-bit word crossing into another clock
//   domain. The word is parked on unsync_bus, then bus_enable is raised as a
//   level request. The destination synchronizes only bus_enable and returns
//   its synchronized copy as ack_async, closing a 4-phase req/ack handshake.
//   The bus is loaded one cycle before the request rises and stays frozen
//   until the handshake has fully returned to idle.
//
// Ports
//   clk        in   source-domain clock
//   rst        in   asynchronous, active-low reset
//   tx_data    in   word to send, sampled when tx_valid & tx_ready
//   tx_valid   in   source has a word
//   tx_ready   out  block can accept a word this cycle
//   unsync_bus out  registered word toward the destination
//   bus_enable out  registered request level toward the destination
//   ack_async  in   destination's synchronized bus_enable (asynchronous here)
//   tx_done    out  one-cycle pulse when a handshake completes
//   busy       out  high whenever a transfer is in progress
module data_sync_tx #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  input  logic                 ack_async,
  output logic                 tx_done,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    REQ     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [NUM_STAGES-1:0] ack_ff;
  logic                  ack_sync;
  logic                  load;
  logic                  en_nxt;
  logic                  done_nxt;

  // Ack synchronizer: only the last stage is ever used by the control logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_ff <= '0;
    end else begin
      ack_ff <= {ack_ff[NUM_STAGES-2:0], ack_async};
    end
  end

  assign ack_sync = ack_ff[NUM_STAGES-1];

  // A stale ack left over from the previous handshake (or destination reset
  // skew) must drain before a new word may be accepted.
  assign tx_ready = (state == IDLE) & ~ack_sync;
  assign busy     = (state != IDLE);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bus_enable <= 1'b0;
      tx_done    <= 1'b0;
      unsync_bus <= '0;
    end else begin
      state      <= state_nxt;
      bus_enable <= en_nxt;
      tx_done    <= done_nxt;
      if (load) begin
        unsync_bus <= tx_data;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tx_valid && tx_ready) state_nxt = SETUP;
      SETUP:   state_nxt = REQ;
      REQ:     if (ack_sync) state_nxt = RELEASE;
      RELEASE: if (!ack_sync) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode. SETUP exists only so the bus has settled for a full cycle
  // before the request rises; REQ always lasts at least one cycle even if an
  // ack is already present on entry.
  always_comb begin
    load     = 1'b0;
    en_nxt   = bus_enable;
    done_nxt = 1'b0;
    case (state)
      IDLE:    load = tx_valid & tx_ready;
      SETUP:   en_nxt = 1'b1;
      REQ:     if (ack_sync) en_nxt = 1'b0;
      RELEASE: if (!ack_sync) done_nxt = 1'b1;
      default: en_nxt = 1'b0;
    endcase
  end

endmodule
